// File: rtl/m_unit_iterative.sv
// m_unit_iterative: RV32M multiply/divide unit for the execute stage.
// Multiplies take MUL_STAGES cycles. Divides and remainders resolve UNROLL
// quotient bits per cycle, using a restoring divider on absolute values.
// A final FIX cycle applies the sign correction.
// Optional feature: define MDU_EARLY_OUT_EN to enable single-cycle early-out
// paths (small dividend, zero multiplicand). Results are the same either way.
module m_unit_iterative #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int UNROLL     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      dest_in,
  input  logic            flush,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      dest,
  output logic            wr
);
  localparam int ITERS = XLEN / UNROLL;
  localparam int MCW   = $clog2(MUL_STAGES + 1);
  localparam int DCW   = $clog2(ITERS + 1);
  localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_STAGES - 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(ITERS - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t          state_q, state_nx;
  logic [XLEN-1:0] a_q, b_q, quo_q, rem_q;
  logic [1:0]      fn_q;
  logic            neg_q_q, neg_r_q;
  logic [MCW-1:0]  mcnt_q;
  logic [DCW-1:0]  dcnt_q;

  // ---- launch decode, evaluated on the live inputs while idle ----
  logic            accept, div_sgn, op1_neg, op2_neg;
  logic            div_zero, div_ovf, div_early, div_spec, mul_fast;
  logic [XLEN-1:0] abs1, abs2, spec_res;

  assign accept   = start & ~flush & (state_q == S_IDLE);
  assign div_sgn  = ~func3[0];
  assign op1_neg  = div_sgn & op1[XLEN-1];
  assign op2_neg  = div_sgn & op2[XLEN-1];
  assign abs1     = op1_neg ? -op1 : op1;
  assign abs2     = op2_neg ? -op2 : op2;
  assign div_zero = ~|op2;
  assign div_ovf  = div_sgn & (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (&op2);
`ifdef MDU_EARLY_OUT_EN
  assign div_early = ~div_zero & (abs1 < abs2);
  assign mul_fast  = (MUL_STAGES == 1) | ~|op1 | ~|op2;
`else
  assign div_early = 1'b0;
  assign mul_fast  = (MUL_STAGES == 1);
`endif
  assign div_spec = div_zero | div_ovf | div_early;
  // Quotient / remainder of the special cases. The early-out case has a quotient
  // of 0 and a remainder of op1, which already carries the dividend's sign.
  assign spec_res = func3[1] ? ((div_zero | div_early) ? op1 : '0)
                             : (div_zero ? '1 : (div_ovf ? op1 : '0));

  // ---- multiplier: live inputs while idle (single-cycle path), captured operands otherwise ----
  logic [XLEN-1:0]   m_a, m_b, mul_res;
  logic [1:0]        m_fn;
  logic              m_a_sx, m_b_sx;
  logic [2*XLEN-1:0] prod;

  assign m_a     = (state_q == S_IDLE) ? op1 : a_q;
  assign m_b     = (state_q == S_IDLE) ? op2 : b_q;
  assign m_fn    = (state_q == S_IDLE) ? func3[1:0] : fn_q;
  assign m_a_sx  = (m_fn != 2'b11) & m_a[XLEN-1];   // signed unless MULHU
  assign m_b_sx  = ~m_fn[1] & m_b[XLEN-1];          // signed for MUL/MULH
  assign prod    = {{XLEN{m_a_sx}}, m_a} * {{XLEN{m_b_sx}}, m_b};
  assign mul_res = (m_fn == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // ---- restoring divide step: UNROLL quotient bits per cycle ----
  logic [XLEN-1:0] q_nx, r_nx;
  logic [XLEN:0]   r_sh;
  // Shift one dividend bit into the partial remainder per inner step; subtract if it fits.
  always_comb begin
    q_nx = quo_q;
    r_nx = rem_q;
    r_sh = '0;
    for (int i = 0; i < UNROLL; i++) begin
      r_sh = {r_nx, q_nx[XLEN-1]};
      q_nx = {q_nx[XLEN-2:0], 1'b0};
      if (r_sh >= {1'b0, b_q}) begin
        r_sh    = r_sh - {1'b0, b_q};
        q_nx[0] = 1'b1;
      end
      r_nx = r_sh[XLEN-1:0];
    end
  end

  logic [XLEN-1:0] q_fix, r_fix, fix_res;
  assign q_fix   = neg_q_q ? -quo_q : quo_q;
  assign r_fix   = neg_r_q ? -rem_q : rem_q;
  assign fix_res = fn_q[1] ? r_fix : q_fix;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nx;
  end

  // Next-state logic. Flush overrides everything, and a DONE cycle goes to IDLE anyway.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (func3[2]) state_nx = div_spec ? S_DONE : S_DIV;
        else          state_nx = mul_fast ? S_DONE : S_MUL;
      end
      S_MUL:  if (mcnt_q == MUL_LAST) state_nx = S_DONE;
      S_DIV:  if (dcnt_q == DIV_LAST) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  // Datapath: capture operands at launch, iterate, fix up signs, and load the result when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      dest    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      fn_q    <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      mcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      if (state_nx == S_DONE)
        result <= (state_q == S_FIX) ? fix_res
                : ((state_q == S_IDLE) && func3[2]) ? spec_res : mul_res;
      case (state_q)
        S_IDLE: if (accept) begin
          dest    <= dest_in;
          fn_q    <= func3[1:0];
          a_q     <= op1;
          b_q     <= func3[2] ? abs2 : op2;
          quo_q   <= abs1;
          rem_q   <= '0;
          neg_q_q <= op1_neg ^ op2_neg;
          neg_r_q <= op1_neg;
          mcnt_q  <= MCW'(1);
          dcnt_q  <= '0;
        end
        S_MUL: mcnt_q <= mcnt_q + MCW'(1);
        S_DIV: begin
          quo_q  <= q_nx;
          rem_q  <= r_nx;
          dcnt_q <= dcnt_q + DCW'(1);
        end
        S_FIX: begin
          quo_q <= q_fix;
          rem_q <= r_fix;
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX);
  assign ready = (state_q == S_DONE);
  assign wr    = ready & (|dest);

endmodule

// File: tb/tb_m_unit_iterative.sv
// Testbench for m_unit_iterative: directed literal cases plus randomized ops.
// A plain-arithmetic reference model predicts the result and latency of each
// op. A single negedge process compares all outputs against that model.
module tb_m_unit_iterative;
  localparam int XLEN  = 32;
  localparam int MS    = 2;
  localparam int UN    = 1;
  localparam int DIV_N = XLEN / UN + 2;
  localparam int BIG   = 1 << 30;
`ifdef MDU_EARLY_OUT_EN
  localparam int EARLY_N = 1;
`else
  localparam int EARLY_N = DIV_N;
`endif

  logic        clk = 0, rst_n = 1, start = 0, flush = 0;
  logic [2:0]  func3 = 0;
  logic [31:0] op1 = 0, op2 = 0;
  logic [4:0]  dest_in = 0;
  logic        busy, ready, wr;
  logic [31:0] result;
  logic [4:0]  dest;

  m_unit_iterative #(.XLEN(XLEN), .MUL_STAGES(MS), .UNROLL(UN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func3(func3), .op1(op1), .op2(op2),
    .dest_in(dest_in), .flush(flush), .busy(busy), .ready(ready), .result(result),
    .dest(dest), .wr(wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  // Model of the current/last op. These are written only by the driver.
  int          p_start = BIG, p_rdy = -1, p_end = -1, p_last = -1;
  logic [31:0] p_res = 0, prev_res = 0;
  logic [4:0]  p_dest = 0, prev_dest = 0;
  bit          lit_en = 0;
  logic [31:0] lit_res = 0;
  int          lit_lat = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: RV32M semantics from plain integer arithmetic, plus the expected latency.
  function automatic void ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output int n);
    longint sa, sb, la, lb;
    logic [63:0] p;
    logic [31:0] q, rm;
    int ia, ib;
    bit sgn;
    ia = a; ib = b;
    if (!f[2]) begin
      sa = (f == 3'b011) ? longint'(a) : longint'(ia);
      sb = f[1] ? longint'(b) : longint'(ib);
      p  = 64'(sa * sb);
      r  = (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
      n  = MS;
`ifdef MDU_EARLY_OUT_EN
      if (a == 0 || b == 0) n = 1;
`endif
    end else begin
      sgn = !f[0];
      if (b == 0) begin q = '1; rm = a; n = 1; end
      else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; rm = 0; n = 1; end
      else begin
        if (sgn) begin q = 32'(ia / ib); rm = 32'(ia % ib); end
        else     begin q = a / b;        rm = a % b;        end
        n = DIV_N;
        la = sgn ? ((ia < 0) ? -longint'(ia) : longint'(ia)) : longint'(a);
        lb = sgn ? ((ib < 0) ? -longint'(ib) : longint'(ib)) : longint'(b);
`ifdef MDU_EARLY_OUT_EN
        if (la < lb) n = 1;
`else
        if (la < 0 || lb < 0) n = DIV_N;
`endif
      end
      r = f[1] ? rm : q;
    end
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic er, eb;
    logic [31:0] eres;
    logic [4:0] ed;
    er   = (cyc == p_rdy);
    eb   = (cyc > p_start) && (cyc < p_end);
    eres = (p_rdy >= 0 && cyc >= p_rdy) ? p_res : prev_res;
    ed   = (cyc > p_start) ? p_dest : prev_dest;
    chk("ready",  32'(ready), 32'(er));
    chk("busy",   32'(busy),  32'(eb));
    chk("wr",     32'(wr),    32'(er && ed != 0));
    chk("result", result,     eres);
    chk("dest",   32'(dest),  32'(ed));
    if (ready && lit_en && cyc > p_start) begin
      chk("lit_result",  result,            lit_res);
      chk("lit_latency", 32'(cyc - p_start), 32'(lit_lat));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && cyc <= p_last; i++) step();
    if (cyc <= p_last) begin
      $display("FAIL wait_idle timeout cycle %0d", cyc);
      $fatal(1, "timeout");
    end
  endtask

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input bit le, input logic [31:0] lr, input int ln);
    logic [31:0] r;
    int n;
    wait_idle();
    ref_op(f, a, b, r, n);
    if (p_rdy >= 0) prev_res = p_res;
    prev_dest = p_dest;
    lit_en = le; lit_res = lr; lit_lat = ln;
    p_res = r; p_dest = d; p_start = cyc; p_rdy = cyc + n; p_end = p_rdy; p_last = p_rdy;
    start = 1; func3 = f; op1 = a; op2 = b; dest_in = d;
    step();
    // Operands are free to change after the launch cycle.
    start = 0; func3 = 3'($urandom); op1 = $urandom; op2 = $urandom; dest_in = 5'($urandom);
  endtask

  // A flush before the DONE cycle aborts the op. In the DONE cycle the ready pulse still happens.
  task automatic do_flush();
    flush = 1;
    if (cyc < p_rdy) begin p_rdy = -1; p_end = cyc + 1; p_last = cyc; end
    step();
    flush = 0;
  endtask

  // Start pulse that must be ignored (busy or DONE); its dest must not be captured.
  task automatic poke();
    start = 1; func3 = 3'($urandom); op1 = $urandom; op2 = $urandom; dest_in = 5'd31;
    step();
    start = 0;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int sel, span;
    #1 rst_n = 0;
    repeat (3) step();
    rst_n = 1;

    // Directed cases with hand-computed results and latencies.
    launch(3'b000, 32'd7,        32'hFFFF_FFFD, 5'd3,  1, 32'hFFFF_FFEB, 2);
    launch(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1, 32'hFFFF_FFFE, 2);
    launch(3'b010, 32'hFFFF_FFFF, 32'd2,        5'd5,  1, 32'hFFFF_FFFF, 2);
    launch(3'b100, 32'hFFFF_FFEC, 32'd3,        5'd6,  1, 32'hFFFF_FFFA, 34);
    launch(3'b110, 32'hFFFF_FFEC, 32'd3,        5'd7,  1, 32'hFFFF_FFFE, 34);
    launch(3'b101, 32'd123,      32'd0,         5'd8,  1, 32'hFFFF_FFFF, 1);
    launch(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1, 32'h8000_0000, 1);
    launch(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1, 32'h0,        1);
    // Flush in cycle 10 of a DIVU, then a new start in cycle 11.
    launch(3'b101, 32'd100,      32'd7,         5'd11, 0, 32'h0,         0);
    repeat (9) step();
    do_flush();
    launch(3'b101, 32'd100,      32'd7,         5'd12, 1, 32'd14,        34);
    // dest 0: ready without wr.
    launch(3'b000, 32'd3,        32'd5,         5'd0,  1, 32'd15,        2);
    // Start while busy is ignored.
    launch(3'b101, 32'd1000,     32'd3,         5'd14, 1, 32'd333,       34);
    repeat (5) step();
    poke();
    launch(3'b101, 32'd5,        32'd9,         5'd15, 1, 32'd0,         EARLY_N);
    // Flush together with start while idle: the start is ignored.
    wait_idle();
    start = 1; flush = 1; func3 = 3'b000; op1 = 32'd2; op2 = 32'd2; dest_in = 5'd31;
    step();
    start = 0; flush = 0;
    // Start during DONE is ignored.
    launch(3'b000, 32'd6,        32'd7,         5'd16, 1, 32'd42,        2);
    poke();
    // Flush during DONE: ready still appears.
    launch(3'b111, 32'd17,       32'd5,         5'd17, 0, 32'h0,         0);
    while (cyc < p_rdy) step();
    do_flush();
    // Reset mid-op.
    launch(3'b100, 32'd77,       32'd5,         5'd18, 0, 32'h0,         0);
    repeat (5) step();
    rst_n = 0;
    p_start = BIG; p_rdy = -1; p_end = -1; p_last = -1;
    p_res = 0; p_dest = 0; prev_res = 0; prev_dest = 0; lit_en = 0;
    repeat (2) step();
    rst_n = 1;

    // Randomized ops with occasional flushes and ignored starts.
    for (int k = 0; k < 150; k++) begin
      launch(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 5'($urandom), 0, 32'h0, 0);
      sel  = $urandom_range(0, 9);
      span = p_rdy - p_start - 1;
      if (sel == 0) begin
        repeat ($urandom_range(0, span)) step();
        do_flush();
      end else if (sel == 1) begin
        repeat ($urandom_range(0, span)) step();
        poke();
      end
    end

    wait_idle();
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
